// File: rtl/user_data_check_if.sv
// RX AXI-stream bundle for one Aurora lane (no back-pressure, so no tready).
// The generator drives through master; the checker listens through slave.
interface user_data_check_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;

  modport master (output tdata, output tkeep, output tlast, output tvalid);
  modport slave  (input  tdata, input  tkeep, input  tlast, input  tvalid);
endinterface

// File: rtl/user_data_check.sv
// Receive-side checker for Aurora 64B66B user-data loopback frames: validates header, sequence,
// length, payload and tkeep; emits per-frame pulses, saturating counters and sticky error flags.
module user_data_check #(
  parameter int unsigned P_FRAME_LEN = 16,
  parameter logic [31:0] P_HEADER    = 32'hA5A5_5A5A
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_channel_up,
  user_data_check_if.slave        s_axi_rx,
  output logic                    o_frame_ok,
  output logic                    o_frame_err,
  output logic [31:0]             o_good_cnt,
  output logic [31:0]             o_err_cnt,
  output logic [3:0]              o_err_flags,
  output logic                    o_locked
);

  typedef enum logic [1:0] {StIdle, StData, StDrop} state_e;

  localparam logic [15:0] LastIdx = 16'(P_FRAME_LEN - 1);

  state_e      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] seq_q, seq_d;
  logic        locked_q, locked_d;
  logic [3:0]  acc_q, acc_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic [31:0] good_cnt_q, good_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;
  logic [3:0]  flags_q, flags_d;

  // Error bit order: {keep, data, len, seq}
  logic [3:0]  beat_err;
  logic [3:0]  frame_errs;
  logic        frame_end;
  logic        keep_bad;
  logic        is_header;
  logic [15:0] rx_seq;
  logic [63:0] exp_word;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    locked_d  = locked_q;
    acc_d     = acc_q;
    beat_err  = '0;
    frame_end = 1'b0;
    keep_bad  = s_axi_rx.tkeep != 8'hFF;
    is_header = s_axi_rx.tdata[63:32] == P_HEADER;
    rx_seq    = s_axi_rx.tdata[15:0];
    exp_word  = {seq_q, 16'h0000, 16'h0000, idx_q};

    if (!i_channel_up) begin
      // Abandon any in-flight frame silently; the next header re-locks.
      state_d  = StIdle;
      idx_d    = '0;
      locked_d = 1'b0;
      acc_d    = '0;
    end else if (s_axi_rx.tvalid) begin
      unique case (state_q)
        StIdle: begin
          if (is_header) begin
            beat_err[3] = keep_bad;
            beat_err[0] = locked_q && (rx_seq != seq_q + 16'd1);
            seq_d       = rx_seq;
            locked_d    = 1'b1;
            if (s_axi_rx.tlast) begin
              beat_err[1] = 1'b1;
              frame_end   = 1'b1;
              acc_d       = '0;
            end else begin
              state_d = StData;
              idx_d   = 16'd1;
              acc_d   = beat_err;
            end
          end
        end
        StData: begin
          beat_err[3] = keep_bad;
          beat_err[2] = s_axi_rx.tdata != exp_word;
          if (idx_q == LastIdx) begin
            if (s_axi_rx.tlast) begin
              frame_end = 1'b1;
              state_d   = StIdle;
            end else begin
              beat_err[1] = 1'b1;
              state_d     = StDrop;
            end
          end else if (s_axi_rx.tlast) begin
            beat_err[1] = 1'b1;
            frame_end   = 1'b1;
            state_d     = StIdle;
          end else begin
            idx_d = idx_q + 16'd1;
          end
          acc_d = frame_end ? 4'b0000 : (acc_q | beat_err);
        end
        StDrop: begin
          if (s_axi_rx.tlast) begin
            frame_end = 1'b1;
            state_d   = StIdle;
            acc_d     = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    frame_errs = acc_q | beat_err;
    ok_d       = frame_end && (frame_errs == 4'b0000);
    err_d      = frame_end && (frame_errs != 4'b0000);
    good_cnt_d = good_cnt_q;
    err_cnt_d  = err_cnt_q;
    flags_d    = flags_q;
    if (ok_d && (good_cnt_q != 32'hFFFF_FFFF)) begin
      good_cnt_d = good_cnt_q + 32'd1;
    end
    if (err_d && (err_cnt_q != 32'hFFFF_FFFF)) begin
      err_cnt_d = err_cnt_q + 32'd1;
    end
    if (frame_end) begin
      flags_d = flags_q | frame_errs;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      seq_q      <= '0;
      locked_q   <= 1'b0;
      acc_q      <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      good_cnt_q <= '0;
      err_cnt_q  <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      seq_q      <= seq_d;
      locked_q   <= locked_d;
      acc_q      <= acc_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      good_cnt_q <= good_cnt_d;
      err_cnt_q  <= err_cnt_d;
      flags_q    <= flags_d;
    end
  end

  assign o_frame_ok  = ok_q;
  assign o_frame_err = err_q;
  assign o_good_cnt  = good_cnt_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_err_flags = flags_q;
  assign o_locked    = locked_q;

endmodule

// File: tb/tb_user_data_check.sv
// Directed bench for user_data_check: drives hand-built loopback frames and compares pulse counts,
// counters, flags and lock state against hand-computed values.
module tb_user_data_check;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        chan_up = 1'b0;
  logic        frame_ok, frame_err, locked;
  logic [31:0] good_cnt, err_cnt;
  logic [3:0]  err_flags;

  int n_checks = 0;
  int n_pass   = 0;
  int ok_seen  = 0;
  int err_seen = 0;
  int ok_base  = 0;
  int err_base = 0;

  user_data_check_if rx_if ();

  user_data_check #(
    .P_FRAME_LEN (16),
    .P_HEADER    (32'hA5A5_5A5A)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_channel_up (chan_up),
    .s_axi_rx     (rx_if),
    .o_frame_ok   (frame_ok),
    .o_frame_err  (frame_err),
    .o_good_cnt   (good_cnt),
    .o_err_cnt    (err_cnt),
    .o_err_flags  (err_flags),
    .o_locked     (locked)
  );

  always #5 clk = ~clk;

  // Pulses are one cycle wide, so counting them at every falling edge catches each exactly once.
  always @(negedge clk) begin
    if (frame_ok)  ok_seen++;
    if (frame_err) err_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    @(negedge clk);
    rx_if.tdata  = d;
    rx_if.tkeep  = k;
    rx_if.tlast  = l;
    rx_if.tvalid = 1'b1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    rx_if.tvalid = 1'b0;
    rx_if.tlast  = 1'b0;
  endtask

  task automatic settle();
    idle_cycle();
    repeat (2) @(negedge clk);
    #1;
  endtask

  // Sends words 0..n_words-1; tlast on word last_at; optional bit flip / short keep on one word.
  task automatic send_frame(input logic [15:0] seq, input int n_words, input int last_at,
                            input int flip_at, input int keep_at, input int gap_pct);
    logic [63:0] w;
    logic [7:0]  k;
    for (int i = 0; i < n_words; i++) begin
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) idle_cycle();
      if (i == 0) w = {32'hA5A5_5A5A, 16'h0000, seq};
      else        w = {seq, 16'h0000, 32'(i)};
      if (i == flip_at) w[0] = ~w[0];
      k = (i == keep_at) ? 8'h0F : 8'hFF;
      beat(w, k, i == last_at);
    end
  endtask

  task automatic good_frame(input logic [15:0] seq, input int gap_pct);
    send_frame(seq, 16, 15, -1, -1, gap_pct);
  endtask

  task automatic do_reset();
    rx_if.tvalid = 1'b0;
    rx_if.tlast  = 1'b0;
    chan_up      = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    ok_base  = ok_seen;
    err_base = err_seen;
  endtask

  initial begin
    rx_if.tdata  = '0;
    rx_if.tkeep  = '0;
    rx_if.tlast  = 1'b0;
    rx_if.tvalid = 1'b0;

    // Reset state
    do_reset();
    #1;
    check("rst_ok", 32'(frame_ok), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_good", good_cnt, 32'd0);
    check("rst_errcnt", err_cnt, 32'd0);
    check("rst_flags", 32'(err_flags), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);

    // Three back-to-back good frames
    good_frame(16'd0, 0);
    good_frame(16'd1, 0);
    good_frame(16'd2, 0);
    settle();
    check("b2b_okpulses", 32'(ok_seen - ok_base), 32'd3);
    check("b2b_errpulses", 32'(err_seen - err_base), 32'd0);
    check("b2b_good", good_cnt, 32'd3);
    check("b2b_errcnt", err_cnt, 32'd0);
    check("b2b_flags", 32'(err_flags), 32'd0);
    check("b2b_locked", 32'(locked), 32'd1);

    // Sequence skip 5 -> 7, then 8 accepted
    do_reset();
    good_frame(16'd5, 0);
    good_frame(16'd7, 0);
    settle();
    check("seq_okpulses", 32'(ok_seen - ok_base), 32'd1);
    check("seq_errpulses", 32'(err_seen - err_base), 32'd1);
    check("seq_flags", 32'(err_flags), 32'h1);
    good_frame(16'd8, 0);
    settle();
    check("seq_resync_good", good_cnt, 32'd2);
    check("seq_resync_err", err_cnt, 32'd1);

    // Short frame (tlast on word 9), then 20-word frame
    do_reset();
    send_frame(16'd0, 10, 9, -1, -1, 0);
    settle();
    check("short_errcnt", err_cnt, 32'd1);
    check("short_flags", 32'(err_flags), 32'h2);
    send_frame(16'd1, 20, 19, -1, -1, 0);
    settle();
    check("long_errpulses", 32'(err_seen - err_base), 32'd2);
    check("long_errcnt", err_cnt, 32'd2);
    check("long_good", good_cnt, 32'd0);

    // Payload bit flip on word 4
    do_reset();
    send_frame(16'd0, 16, 15, 4, -1, 0);
    settle();
    check("data_flags", 32'(err_flags), 32'h4);
    check("data_errcnt", err_cnt, 32'd1);

    // Short tkeep on word 3
    do_reset();
    send_frame(16'd0, 16, 15, -1, 3, 0);
    settle();
    check("keep_flags", 32'(err_flags), 32'h8);
    check("keep_errpulses", 32'(err_seen - err_base), 32'd1);

    // Sequence wrap, then the same mix again with 30% valid gaps
    do_reset();
    good_frame(16'hFFFF, 0);
    good_frame(16'h0000, 0);
    settle();
    check("wrap_good", good_cnt, 32'd2);
    check("wrap_flags", 32'(err_flags), 32'h0);
    good_frame(16'd1, 30);
    good_frame(16'd3, 30);
    good_frame(16'd4, 30);
    settle();
    check("gap_good", good_cnt, 32'd4);
    check("gap_errcnt", err_cnt, 32'd1);
    check("gap_flags", 32'(err_flags), 32'h1);

    // Channel drop mid-frame
    do_reset();
    good_frame(16'd0, 0);
    send_frame(16'd1, 7, -1, -1, -1, 0);
    @(negedge clk);
    rx_if.tvalid = 1'b0;
    chan_up      = 1'b0;
    settle();
    check("chdown_locked", 32'(locked), 32'd0);
    check("chdown_good", good_cnt, 32'd1);
    check("chdown_errpulses", 32'(err_seen - err_base), 32'd0);
    chan_up = 1'b1;
    settle();
    good_frame(16'd9, 0);
    settle();
    check("chup_locked", 32'(locked), 32'd1);
    check("chup_good", good_cnt, 32'd2);
    check("chup_errcnt", err_cnt, 32'd0);
    check("chup_flags", 32'(err_flags), 32'h0);

    // Async reset mid-frame, then re-lock on an arbitrary sequence
    do_reset();
    good_frame(16'd0, 0);
    send_frame(16'd1, 6, -1, -1, -1, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_good", good_cnt, 32'd0);
    rx_if.tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    good_frame(16'd3, 0);
    settle();
    check("arst_relock_good", good_cnt, 32'd1);
    check("arst_relock_flags", 32'(err_flags), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
